// File: rtl/modn_seq_pkg.sv
// Shared definitions for the mod-N sequencer: state encoding and default widths.
package modn_seq_pkg;
  localparam int WIDTH_D  = 4;
  localparam int REPS_W_D = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/modn_ctr_ld.sv
// Mod-N counter with a runtime modulus. clr has priority over en.
// wrap is combinational and marks the enabled cycle where count == mod-1.
module modn_ctr_ld #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] mod,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  logic [WIDTH-1:0] last;

  // Compare against mod-1 in WIDTH bits so the counter never passes the top value.
  assign last = mod - WIDTH'(1);
  assign wrap = en && (count == last);

  // Count state: clear, wrap to zero, or increment.
  always_ff @(posedge clk) begin
    if (rst || clr)  count <= '0;
    else if (en)     count <= wrap ? '0 : count + WIDTH'(1);
  end
endmodule

// File: rtl/modn_seq_ctrl.sv
// Sequencer: accepts a (modulus, repetitions) configuration, runs a mod-N counter
// for that many periods, flags each wrap and pulses done after the final one.
module modn_seq_ctrl
  import modn_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_D,
  parameter int REPS_W = REPS_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_mod,
  input  logic [REPS_W-1:0] cfg_reps,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic [REPS_W-1:0] rep_cnt,
  output logic              tick,
  output logic              busy,
  output logic              done,
  output logic              err
);
  logic [1:0]        state;
  logic [WIDTH-1:0]  mod_q;
  logic [REPS_W-1:0] reps_q;
  logic              accept, cfg_bad, in_run, wrap, final_wrap, ctr_clr;

  assign in_run     = (state == S_RUN);
  assign cfg_ready  = (state == S_IDLE);
  assign busy       = in_run;
  assign accept     = cfg_valid && cfg_ready;
  assign cfg_bad    = (cfg_mod == '0) || (cfg_reps == '0);
  assign final_wrap = wrap && (rep_cnt == reps_q - REPS_W'(1));
  assign tick       = wrap;

  // Counter restarts on a good accept, on abort and when the run ends.
  assign ctr_clr = (accept && !cfg_bad) || (in_run && (abort || final_wrap));

  modn_ctr_ld #(.WIDTH(WIDTH)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (in_run),
    .clr   (ctr_clr),
    .mod   (mod_q),
    .count (count),
    .wrap  (wrap)
  );

  // Control FSM, configuration latches, period counter and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mod_q   <= '0;
      reps_q  <= '0;
      rep_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              mod_q   <= cfg_mod;
              reps_q  <= cfg_reps;
              rep_cnt <= '0;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Abort wins even over the final wrap.
          if (abort) begin
            rep_cnt <= '0;
            state   <= S_IDLE;
          end else if (wrap) begin
            rep_cnt <= rep_cnt + REPS_W'(1);
            if (final_wrap) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/modn_seq_ctrl.md
Name: modn_seq_ctrl

Overview:
Sequencer that configures and drives a runtime-programmable mod-N counter for a programmed number of wrap periods. Accepts a configuration over a valid/ready handshake, runs the counter, flags each wrap, and pulses done after the last period. Used as the timing/pacing controller in front of counter-based datapaths. Also supports abort.

Parameters:
WIDTH, 4, counter width; legal modulus range is 1 .. 2^WIDTH-1.
REPS_W, 8, repetition-count width; legal reps range is 1 .. 2^REPS_W-1.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset; synchronous, active-high.
cfg_valid  in  1  configuration offered.
cfg_ready  out  1  controller can accept a configuration; high only in IDLE.
cfg_mod  in  WIDTH  modulus N, sampled on handshake.
cfg_reps  in  REPS_W  number of mod-N periods to run, sampled on handshake.
abort  in  1  stop the run; honoured only in RUN.
count  out  WIDTH  current counter value.
rep_cnt  out  REPS_W  number of completed periods in the current run.
tick  out  1  high in each RUN cycle where count == mod_q-1 (wrap cycle).
busy  out  1  high in RUN.
done  out  1  one-cycle pulse after the final wrap.
err  out  1  one-cycle pulse when a configuration is rejected.

Behaviour:
- Reset (rst high at a posedge): state IDLE; count=0, rep_cnt=0, mod_q=0, reps_q=0; registered done=0, err=0. Derived outputs after reset: cfg_ready=1, busy=0, tick=0. Reset overrides all other inputs, including during RUN.
- States:
  - IDLE: cfg_ready=1.
  - RUN: busy=1, cfg_ready=0.
  - DONE: one cycle, done=1, cfg_ready=0.
- Handshake: a transfer occurs when cfg_valid && cfg_ready are both high at a posedge. cfg_valid outside IDLE is ignored and has no side effects.
- Invalid configuration (cfg_mod==0 or cfg_reps==0):
  - The transfer is consumed.
  - err=1 in the next cycle.
  - State stays IDLE and no registers change.
- Valid transfer in cycle t:
  - Latch mod_q and reps_q.
  - count=0, rep_cnt=0, state=RUN from cycle t+1.
- RUN, each cycle:
  - If count == mod_q-1: count<=0, rep_cnt<=rep_cnt+1, tick=1.
  - Otherwise: count<=count+1.
- The wrap with rep_cnt == reps_q-1 is the final wrap; next state is DONE.
- Timing: RUN lasts exactly mod_q*reps_q cycles (t+1 .. t+mod*reps).
  - Ticks occur in cycles t+k*mod for k = 1..reps.
  - done is high in cycle t+mod*reps+1.
  - cfg_ready is high again in cycle t+mod*reps+2.
- In DONE: count=0 and rep_cnt holds reps_q.
- mod_q==1: count stays 0 and tick is high every RUN cycle.
- abort in RUN: next cycle IDLE, count=0, rep_cnt=0, no done.
  - abort coincident with the final wrap also wins: no done.
  - abort in IDLE or DONE is ignored.
- Widths: counter compare uses WIDTH bits with no overflow past mod_q-1. rep_cnt never exceeds reps_q.

Decomposition:
- Shared package modn_seq_pkg holds:
  - state encoding localparams S_IDLE=0, S_RUN=1, S_DONE=2 (2-bit);
  - default WIDTH and REPS_W.
- One sub-module, modn_ctr_ld: mod-N counter with inputs en, clr and a runtime modulus; outputs count and wrap.
  - It implements the count/wrap datapath.
  - The FSM in modn_seq_ctrl drives en=(state==RUN) and clr (on accept, on abort, and on leaving RUN).

Test Plan:
1. Reset: rst=1 for 2 cycles with cfg_valid=1 -> no accept. After release: cfg_ready=1, busy=0, count=0, done=0.
2. cfg_mod=10, cfg_reps=2 accepted at cycle t:
   - count runs 0..9, 0..9;
   - tick at t+10 and t+20;
   - rep_cnt 0->1->2;
   - done at t+21;
   - cfg_ready=1 at t+22.
3. cfg_mod=1, cfg_reps=3:
   - tick high at t+1, t+2, t+3 with count always 0;
   - done at t+4.
   Then cfg_mod=15, cfg_reps=1: wrap 14->0 at t+15, done at t+16.
4. Invalid configuration:
   - cfg_mod=0, cfg_reps=5 -> err pulse one cycle; busy stays 0; cfg_ready stays 1.
   - Repeat with cfg_mod=7, cfg_reps=0 -> same response.
5. abort:
   - cfg_mod=10, cfg_reps=3; abort when count=5 in the first period -> next cycle IDLE, count=0, no done.
   - Second run with abort asserted in the final wrap cycle -> no done; IDLE next cycle.
6. Mid-run disturbances:
   - rst asserted with count=4, rep_cnt=1 -> next cycle all outputs at reset values.
   - cfg_valid with new values held during RUN -> ignored; the run completes with the original mod and reps.
